// File: rtl/eth_axi_rsp_mem.sv
// eth_axi_rsp_mem: single-port AXI4 memory subordinate for the Ethernet DMA, one transaction at a time.
// Define ETH_AXI_RSP_WRAP_EN to support WRAP bursts; axi_req_t/axi_rsp_t must match the AXI4+ATOP layout below.
module eth_axi_rsp_mem #(
    parameter int unsigned AddrWidth  = 48,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned AxiIdWidth = 6,
    parameter int unsigned UserWidth  = 10,
    parameter int unsigned NumWords   = 1024,
    parameter type axi_req_t = logic,
    parameter type axi_rsp_t = logic
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o,
    output logic     busy_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW = $clog2(StrbWidth);
    localparam int unsigned IdxW = $clog2(NumWords);
    typedef logic [AxiIdWidth-1:0] id_t;
    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [UserWidth-1:0] user_t;
    typedef struct packed {
        id_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic lock;
        logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region; logic [5:0] atop; user_t user;
    } aw_chan_t;
    typedef struct packed {data_t data; logic [StrbWidth-1:0] strb; logic last; user_t user;} w_chan_t;
    typedef struct packed {id_t id; logic [1:0] resp; user_t user;} b_chan_t;
    typedef struct packed {
        id_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic lock;
        logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region; user_t user;
    } ar_chan_t;
    typedef struct packed {id_t id; data_t data; logic [1:0] resp; logic last; user_t user;} r_chan_t;
    typedef struct packed {
        aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
        ar_chan_t ar; logic ar_valid; logic r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_t b; logic r_valid; r_chan_t r;
    } rsp_t;
    typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} state_t;

    state_t state, state_d;
    req_t req;
    rsp_t rsp;
    logic prio, err, dec;
    id_t id;
    addr_t addr, step, addr_nxt;
    logic [7:0] len, beat;
    logic [2:0] size;
    logic [1:0] burst;
    user_t user;
    data_t mem [NumWords];
    logic [IdxW-1:0] idx;
    logic illegal, in_range, last_beat, grant_aw, grant_ar, w_hs, r_hs, wrap_ok, unused_ok;

    assign req = req_t'(axi_req_i);
    assign axi_rsp_o = axi_rsp_t'(rsp);
    assign unused_ok = ^req;
    assign busy_o = !rst_i && state != IDLE;
    assign step = AddrWidth'(1) << size;
    assign idx = addr[OffW +: IdxW];
    assign in_range = (addr >> OffW) < AddrWidth'(NumWords);
    assign last_beat = beat == len;
`ifdef ETH_AXI_RSP_WRAP_EN
    addr_t wrap_mask;
    assign wrap_mask = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
    assign wrap_ok = (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) &&
                     ((addr & (step - AddrWidth'(1))) == '0);
    assign addr_nxt = burst == 2'b00 ? addr : burst == 2'b01 ? addr + step :
                      (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
`else
    assign wrap_ok = 1'b0;
    assign addr_nxt = burst == 2'b00 ? addr : addr + step;
`endif
    assign illegal = size > 3'(OffW) || burst == 2'b11 || (burst == 2'b10 && !wrap_ok);
    // Only one address channel can win per cycle; the memory has a single port.
    assign grant_aw = !rst_i && state == IDLE && req.aw_valid && (!req.ar_valid || !prio);
    assign grant_ar = !rst_i && state == IDLE && req.ar_valid && !grant_aw;
    assign w_hs = state == WRITE && req.w_valid;
    assign r_hs = state == READ && req.r_ready;

    always_comb begin
        rsp = '0;
        rsp.aw_ready = grant_aw;
        rsp.ar_ready = grant_ar;
        rsp.w_ready = !rst_i && state == WRITE;
        rsp.b_valid = !rst_i && state == WRITE_RESP;
        rsp.b.id = id;
        rsp.b.user = user;
        rsp.b.resp = dec ? 2'b11 : (illegal || err) ? 2'b10 : 2'b00;
        rsp.r_valid = !rst_i && state == READ;
        rsp.r.id = id;
        rsp.r.user = user;
        rsp.r.data = (in_range && !illegal) ? mem[idx] : '0;
        rsp.r.resp = !in_range ? 2'b11 : illegal ? 2'b10 : 2'b00;
        rsp.r.last = last_beat;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:       state_d = grant_aw ? WRITE : grant_ar ? READ : IDLE;
            WRITE:      state_d = (w_hs && last_beat) ? WRITE_RESP : WRITE;
            WRITE_RESP: state_d = req.b_ready ? IDLE : WRITE_RESP;
            READ:       state_d = (r_hs && last_beat) ? IDLE : READ;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            prio <= 1'b0;
            err <= 1'b0;
            dec <= 1'b0;
            id <= '0;
            addr <= '0;
            len <= '0;
            beat <= '0;
            size <= '0;
            burst <= '0;
            user <= '0;
        end else begin
            state <= state_d;
            if (grant_aw || grant_ar) begin
                prio <= grant_aw;
                id <= grant_aw ? req.aw.id : req.ar.id;
                addr <= grant_aw ? req.aw.addr : req.ar.addr;
                len <= grant_aw ? req.aw.len : req.ar.len;
                size <= grant_aw ? req.aw.size : req.ar.size;
                burst <= grant_aw ? req.aw.burst : req.ar.burst;
                user <= grant_aw ? req.aw.user : req.ar.user;
                beat <= '0;
                err <= 1'b0;
                dec <= 1'b0;
            end
            if (w_hs) begin
                beat <= beat + 8'd1;
                addr <= addr_nxt;
                err <= err || (req.w.last != last_beat);
                dec <= dec || !in_range;
            end
            if (r_hs) begin
                beat <= beat + 8'd1;
                addr <= addr_nxt;
            end
        end
    end

    // Array is deliberately left out of reset so aborted bursts keep their written beats.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_hs && in_range && !illegal)
            for (int b = 0; b < StrbWidth; b++)
                if (req.w.strb[b]) mem[idx][8*b +: 8] <= req.w.data[8*b +: 8];
    end
endmodule

// File: tb/tb_eth_axi_rsp_mem.sv
// tb_eth_axi_rsp_mem: directed self-checking bench for eth_axi_rsp_mem (default parameters).
// Honours ETH_AXI_RSP_WRAP_EN for the WRAP scenario.
module tb_eth_axi_rsp_mem;
    typedef struct packed {
        logic [5:0] id; logic [47:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic lock;
        logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region; logic [5:0] atop; logic [9:0] user;
    } aw_chan_t;
    typedef struct packed {logic [63:0] data; logic [7:0] strb; logic last; logic [9:0] user;} w_chan_t;
    typedef struct packed {logic [5:0] id; logic [1:0] resp; logic [9:0] user;} b_chan_t;
    typedef struct packed {
        logic [5:0] id; logic [47:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic lock;
        logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region; logic [9:0] user;
    } ar_chan_t;
    typedef struct packed {logic [5:0] id; logic [63:0] data; logic [1:0] resp; logic last; logic [9:0] user;} r_chan_t;
    typedef struct packed {
        aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
        ar_chan_t ar; logic ar_valid; logic r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_t b; logic r_valid; r_chan_t r;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    req_t req;
    rsp_t rsp;
    logic busy;
    int cmp = 0;
    int mism = 0;

    eth_axi_rsp_mem #(.axi_req_t(req_t), .axi_rsp_t(rsp_t)) dut (
        .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_rsp_o(rsp), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_for(input int ch, input string nm);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (ch == 0 ? rsp.aw_ready : ch == 1 ? rsp.w_ready : ch == 2 ? rsp.b_valid :
                ch == 3 ? rsp.ar_ready : rsp.r_valid) return;
            @(negedge clk);
        end
        cmp++; mism++;
        $display("FAIL %s: handshake timed out, got none want handshake", nm);
    endtask

    task automatic send_aw(input logic [47:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] bt,
                           input logic [5:0] i);
        req.aw = '0; req.aw.addr = a; req.aw.len = l; req.aw.size = s; req.aw.burst = bt; req.aw.id = i;
        req.aw.user = 10'h3c1; req.aw.atop = 6'h2a; req.aw_valid = 1'b1;
        wait_for(0, "aw_grant");
        @(negedge clk);
        req.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [47:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] bt,
                           input logic [5:0] i);
        req.ar = '0; req.ar.addr = a; req.ar.len = l; req.ar.size = s; req.ar.burst = bt; req.ar.id = i;
        req.ar_valid = 1'b1;
        wait_for(3, "ar_grant");
        @(negedge clk);
        req.ar_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] st, input logic lst);
        req.w = '0; req.w.data = d; req.w.strb = st; req.w.last = lst; req.w_valid = 1'b1;
        wait_for(1, "w_beat");
        @(negedge clk);
        req.w_valid = 1'b0;
    endtask

    task automatic recv_b(output logic [1:0] resp, output logic [5:0] id);
        req.b_ready = 1'b1;
        wait_for(2, "b_resp");
        resp = rsp.b.resp; id = rsp.b.id;
        @(negedge clk);
        req.b_ready = 1'b0;
    endtask

    task automatic recv_r(output logic [63:0] d, output logic [1:0] resp, output logic lst);
        req.r_ready = 1'b1;
        wait_for(4, "r_beat");
        d = rsp.r.data; resp = rsp.r.resp; lst = rsp.r.last;
        @(negedge clk);
        req.r_ready = 1'b0;
    endtask

    task automatic wr(input logic [47:0] a, input logic [7:0] l, input logic [2:0] s, input logic [63:0] base,
                      output logic [1:0] resp);
        logic [5:0] bid;
        send_aw(a, l, s, 2'b01, 6'd0);
        for (int i = 0; i <= int'(l); i++) send_w(base + 64'(i), 8'hff, i == int'(l));
        recv_b(resp, bid);
    endtask

    task automatic test_reset;
        req = '0;
        @(negedge clk);
        req.aw_valid = 1'b1; req.ar_valid = 1'b1; req.w_valid = 1'b1;
        #1;
        cmp++; if (rsp.aw_ready !== 1'b0) begin mism++; $display("FAIL rst_aw_ready: got %b want 0", rsp.aw_ready); end
        cmp++; if (rsp.ar_ready !== 1'b0) begin mism++; $display("FAIL rst_ar_ready: got %b want 0", rsp.ar_ready); end
        cmp++; if (rsp.w_ready !== 1'b0) begin mism++; $display("FAIL rst_w_ready: got %b want 0", rsp.w_ready); end
        cmp++; if ({rsp.b_valid, rsp.r_valid} !== 2'b00) begin mism++; $display("FAIL rst_valids: got %b want 00", {rsp.b_valid, rsp.r_valid}); end
        cmp++; if (busy !== 1'b0) begin mism++; $display("FAIL rst_busy: got %b want 0", busy); end
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        cmp++; if (busy !== 1'b0) begin mism++; $display("FAIL post_rst_busy: got %b want 0", busy); end
        cmp++; if (rsp.b.id !== 6'd0 || rsp.r.last !== 1'b1) begin mism++; $display("FAIL post_rst_fields: got id %h last %b want 0 1", rsp.b.id, rsp.r.last); end
        @(negedge clk);
    endtask

    task automatic test_incr;
        logic [1:0] resp; logic [5:0] bid; logic [63:0] d; logic lst;
        send_aw(48'h40, 8'd3, 3'd3, 2'b01, 6'd5);
        #1;
        cmp++; if (busy !== 1'b1) begin mism++; $display("FAIL incr_busy: got %b want 1", busy); end
        for (int i = 0; i < 4; i++) send_w(64'(i + 1), 8'hff, i == 3);
        recv_b(resp, bid);
        cmp++; if (resp !== 2'b00) begin mism++; $display("FAIL incr_bresp: got %b want 00", resp); end
        cmp++; if (bid !== 6'd5) begin mism++; $display("FAIL incr_bid: got %h want 05", bid); end
        send_ar(48'h40, 8'd3, 3'd3, 2'b01, 6'd9);
        #1;
        cmp++; if (rsp.r_valid !== 1'b1 || rsp.r.id !== 6'd9) begin mism++; $display("FAIL incr_rvalid_first: got %b id %h want 1 09", rsp.r_valid, rsp.r.id); end
        for (int i = 0; i < 4; i++) begin
            recv_r(d, resp, lst);
            cmp++; if (d !== 64'(i + 1) || lst !== (i == 3) || resp !== 2'b00) begin
                mism++; $display("FAIL incr_rbeat%0d: got %h last %b resp %b want %h last %b resp 00", i, d, lst, resp, 64'(i + 1), i == 3);
            end
        end
    endtask

    task automatic test_arbitration;
        logic [1:0] resp; logic [5:0] bid; logic [63:0] d; logic lst;
        req.aw = '0; req.aw.addr = 48'h100; req.aw.size = 3'd3; req.aw.burst = 2'b01; req.aw.id = 6'd1; req.aw_valid = 1'b1;
        req.ar = '0; req.ar.addr = 48'h40; req.ar.size = 3'd3; req.ar.burst = 2'b01; req.ar.id = 6'd2; req.ar_valid = 1'b1;
        #1;
        cmp++; if ({rsp.aw_ready, rsp.ar_ready} !== 2'b10) begin mism++; $display("FAIL arb_first: got aw/ar %b want 10", {rsp.aw_ready, rsp.ar_ready}); end
        @(negedge clk);
        req.aw_valid = 1'b0;
        #1;
        cmp++; if (rsp.ar_ready !== 1'b0) begin mism++; $display("FAIL arb_ar_in_write: got %b want 0", rsp.ar_ready); end
        send_w(64'hb0, 8'hff, 1'b1);
        recv_b(resp, bid);
        req.aw.addr = 48'h108; req.aw.id = 6'd4; req.aw_valid = 1'b1;
        #1;
        cmp++; if ({rsp.aw_ready, rsp.ar_ready} !== 2'b01) begin mism++; $display("FAIL arb_second: got aw/ar %b want 01", {rsp.aw_ready, rsp.ar_ready}); end
        @(negedge clk);
        req.ar_valid = 1'b0;
        recv_r(d, resp, lst);
        cmp++; if (d !== 64'h1 || lst !== 1'b1) begin mism++; $display("FAIL arb_rdata: got %h last %b want 1 1", d, lst); end
        #1;
        cmp++; if (rsp.aw_ready !== 1'b1) begin mism++; $display("FAIL arb_aw_after_read: got %b want 1", rsp.aw_ready); end
        @(negedge clk);
        req.aw_valid = 1'b0;
        send_w(64'hb8, 8'hff, 1'b1);
        recv_b(resp, bid);
        cmp++; if (resp !== 2'b00 || bid !== 6'd4) begin mism++; $display("FAIL arb_b2: got resp %b id %h want 00 04", resp, bid); end
    endtask

    task automatic test_decerr;
        logic [1:0] resp; logic [63:0] d; logic lst;
        wr(48'h0, 8'd0, 3'd3, 64'h1111, resp);
        wr(48'h2000, 8'd0, 3'd3, 64'hdead, resp);
        cmp++; if (resp !== 2'b11) begin mism++; $display("FAIL dec_bresp: got %b want 11", resp); end
        send_ar(48'h0, 8'd0, 3'd3, 2'b01, 6'd0);
        recv_r(d, resp, lst);
        cmp++; if (d !== 64'h1111 || resp !== 2'b00) begin mism++; $display("FAIL dec_unchanged: got %h resp %b want 1111 00", d, resp); end
        send_ar(48'h2000, 8'd0, 3'd3, 2'b01, 6'd0);
        recv_r(d, resp, lst);
        cmp++; if (d !== 64'h0 || resp !== 2'b11) begin mism++; $display("FAIL dec_rd: got %h resp %b want 0 11", d, resp); end
    endtask

    task automatic test_wrap;
        logic [1:0] resp; logic [63:0] d; logic lst;
        logic [63:0] exp_d [4];
        wr(48'h0, 8'd3, 3'd3, 64'ha0, resp);
`ifdef ETH_AXI_RSP_WRAP_EN
        exp_d = '{64'ha3, 64'ha0, 64'ha1, 64'ha2};
`else
        exp_d = '{64'h0, 64'h0, 64'h0, 64'h0};
`endif
        send_ar(48'h18, 8'd3, 3'd3, 2'b10, 6'd3);
        for (int i = 0; i < 4; i++) begin
            recv_r(d, resp, lst);
`ifdef ETH_AXI_RSP_WRAP_EN
            cmp++; if (d !== exp_d[i] || resp !== 2'b00 || lst !== (i == 3)) begin
                mism++; $display("FAIL wrap_beat%0d: got %h resp %b last %b want %h 00 %b", i, d, resp, lst, exp_d[i], i == 3);
            end
`else
            cmp++; if (d !== exp_d[i] || resp !== 2'b10 || lst !== (i == 3)) begin
                mism++; $display("FAIL wrap_beat%0d: got %h resp %b last %b want %h 10 %b", i, d, resp, lst, exp_d[i], i == 3);
            end
`endif
        end
    endtask

    task automatic test_stall;
        logic [1:0] resp; logic [63:0] d; logic lst;
        send_ar(48'h40, 8'd1, 3'd3, 2'b01, 6'd7);
        for (int k = 0; k < 5; k++) begin
            #1;
            cmp++; if (rsp.r_valid !== 1'b1 || rsp.r.data !== 64'h1 || rsp.r.last !== 1'b0 || rsp.r.id !== 6'd7) begin
                mism++; $display("FAIL stall_cyc%0d: got v %b d %h last %b id %h want 1 1 0 07", k, rsp.r_valid, rsp.r.data, rsp.r.last, rsp.r.id);
            end
            @(negedge clk);
        end
        recv_r(d, resp, lst);
        recv_r(d, resp, lst);
        cmp++; if (d !== 64'h2 || lst !== 1'b1) begin mism++; $display("FAIL stall_beat1: got %h last %b want 2 1", d, lst); end
    endtask

    task automatic test_reset_mid;
        logic [1:0] resp; logic [63:0] d; logic lst;
        logic [63:0] exp_d [4];
        exp_d = '{64'h51, 64'h52, 64'h92, 64'h93};
        wr(48'h200, 8'd3, 3'd3, 64'h90, resp);
        send_aw(48'h200, 8'd3, 3'd3, 2'b01, 6'd2);
        send_w(64'h51, 8'hff, 1'b0);
        send_w(64'h52, 8'hff, 1'b0);
        rst = 1'b1;
        #1;
        cmp++; if (busy !== 1'b0 || rsp.w_ready !== 1'b0) begin mism++; $display("FAIL midrst_in: got busy %b wready %b want 0 0", busy, rsp.w_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            cmp++; if (busy !== 1'b0 || rsp.b_valid !== 1'b0) begin mism++; $display("FAIL midrst_after%0d: got busy %b bvalid %b want 0 0", k, busy, rsp.b_valid); end
            @(negedge clk);
        end
        send_ar(48'h200, 8'd3, 3'd3, 2'b01, 6'd0);
        for (int i = 0; i < 4; i++) begin
            recv_r(d, resp, lst);
            cmp++; if (d !== exp_d[i]) begin mism++; $display("FAIL midrst_word%0d: got %h want %h", i, d, exp_d[i]); end
        end
    endtask

    task automatic test_illegal;
        logic [1:0] resp; logic [5:0] bid; logic [63:0] d; logic lst;
        wr(48'h300, 8'd0, 3'd3, 64'h77, resp);
        wr(48'h300, 8'd0, 3'd4, 64'h55, resp);
        cmp++; if (resp !== 2'b10) begin mism++; $display("FAIL bigsize_bresp: got %b want 10", resp); end
        send_ar(48'h300, 8'd0, 3'd3, 2'b01, 6'd0);
        recv_r(d, resp, lst);
        cmp++; if (d !== 64'h77) begin mism++; $display("FAIL bigsize_nowrite: got %h want 77", d); end
        send_ar(48'h40, 8'd0, 3'd3, 2'b11, 6'd0);
        recv_r(d, resp, lst);
        cmp++; if (d !== 64'h0 || resp !== 2'b10 || lst !== 1'b1) begin mism++; $display("FAIL rsvd_burst: got %h resp %b last %b want 0 10 1", d, resp, lst); end
        send_aw(48'h310, 8'd1, 3'd3, 2'b01, 6'd6);
        send_w(64'he1, 8'hff, 1'b1);
        send_w(64'he2, 8'h0f, 1'b0);
        recv_b(resp, bid);
        cmp++; if (resp !== 2'b10 || bid !== 6'd6) begin mism++; $display("FAIL early_last_bresp: got %b id %h want 10 06", resp, bid); end
        send_ar(48'h318, 8'd0, 3'd3, 2'b01, 6'd0);
        recv_r(d, resp, lst);
        cmp++; if (d[31:0] !== 32'he2 || resp !== 2'b00) begin mism++; $display("FAIL early_last_beat2: got %h resp %b want e2 00", d[31:0], resp); end
    endtask

    initial begin
        test_reset;
        test_incr;
        test_arbitration;
        test_decerr;
        test_wrap;
        test_stall;
        test_reset_mid;
        test_illegal;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule

// File: doc/eth_axi_rsp_mem.md
ETH_AXI_RSP_MEM -- requirements
Module: eth_axi_rsp_mem

Interface
- REQ-001 SHALL have parameter AddrWidth, default 48, AXI address width.
- REQ-002 SHALL have parameter DataWidth, default 64, AXI data width (power of two, >= 32).
- REQ-003 SHALL have parameter AxiIdWidth, default 6, AXI ID width.
- REQ-004 SHALL have parameter UserWidth, default 10, AXI user width.
- REQ-005 SHALL have parameter NumWords, default 1024, memory depth in DataWidth words (power of two).
- REQ-006 SHALL have type parameters axi_req_t and axi_rsp_t, default logic, AXI4+ATOP request/response structs.
- REQ-007 SHALL have clk_i  input  1  sole clock, all logic rising-edge.
- REQ-008 SHALL have rst_i  input  1  synchronous active-high reset.
- REQ-009 SHALL have axi_req_i  input  axi_req_t  AXI request from the Ethernet DMA initiator.
- REQ-010 SHALL have axi_rsp_o  output  axi_rsp_t  AXI response to the initiator.
- REQ-011 SHALL have busy_o  output  1  high while any transaction is in flight.

Function
- REQ-012 SHALL implement an AXI4 subordinate backed by a NumWords x DataWidth array, one transaction at a time; word index = addr[log2(DataWidth/8) +: log2(NumWords)], in range iff addr >> log2(DataWidth/8) < NumWords.
- REQ-013 SHALL use FSM states IDLE, WRITE, WRITE_RESP, READ; busy_o = (state != IDLE).
- REQ-014 In IDLE SHALL drive aw_ready/ar_ready to grant one valid request; if both valid, grant per priority bit (reset = write); priority bit flips to the other channel after every grant.
- REQ-015 On AW grant SHALL capture id, addr, len, size, burst, user, clear beat counter and error flag, go to WRITE; on AR grant likewise, go to READ.
- REQ-016 In WRITE SHALL hold w_ready=1; each W handshake writes bytes with w.strb set, only if beat legal and in range; beat counter increments.
- REQ-017 Write burst SHALL end on the handshake with beat == len, then go to WRITE_RESP; w.last mismatch (early or missing) SHALL set SLVERR; beats after an early w.last are still consumed until beat == len.
- REQ-018 In WRITE_RESP SHALL drive b_valid=1, b.id/b.user captured, b.resp = DECERR if any beat out of range, else SLVERR if error flag, else OKAY; held stable until b_ready, then IDLE.
- REQ-019 In READ SHALL present r_valid first in the cycle after AR grant, with r.data = array word (zero if out of range or illegal), r.id captured, r.last = (beat == len), r.resp per beat (DECERR/SLVERR/OKAY).
- REQ-020 r payload SHALL stay stable while r_valid && !r_ready; on handshake advance beat; after r.last handshake go to IDLE.
- REQ-021 Address update per beat: FIXED unchanged; INCR addr += 2^size modulo 2^AddrWidth; WRAP per REQ-027.
- REQ-022 size > log2(DataWidth/8) SHALL be SLVERR for whole burst, no writes, zero read data.
- REQ-023 aw.atop SHALL be ignored; reserved burst type 2'b11 SHALL be SLVERR.
- REQ-024 Memory SHALL be single-port; simultaneous AW and AR arrival SHALL never cause both to be granted in the same cycle.

Reset
- REQ-025 While rst_i: state IDLE, all ready/valid outputs 0, busy_o 0, priority bit = write, counters and captured fields 0.
- REQ-026 Reset mid-transaction SHALL abort without issuing B or R; array contents SHALL NOT be reset and keep beats already written.

Configuration
- REQ-027 With ETH_AXI_RSP_WRAP_EN defined, WRAP bursts with len in {1,3,7,15} and addr aligned to 2^size SHALL wrap at (len+1)*2^size boundary; other WRAP bursts SLVERR.
- REQ-028 Without ETH_AXI_RSP_WRAP_EN, every WRAP burst SHALL be SLVERR (no writes, zero read data); no wrap logic SHALL be present.

Verification
- REQ-029 INCR write addr 0x40, len 3, size 3, strb 0xFF, data 1..4 -> B OKAY, one cycle later read back 1,2,3,4, r.last on beat 3 only.
- REQ-030 AW and AR valid same cycle after reset -> AW granted first, AR granted next IDLE; repeated pair -> AR first.
- REQ-031 Write addr NumWords*8 (64-bit data), len 0 -> B DECERR, array unchanged; read same addr -> r.data 0, DECERR.
- REQ-032 With macro: WRAP read addr 0x18, len 3, size 3 -> words at 0x18,0x00,0x08,0x10; without macro -> 4 beats SLVERR, data 0.
- REQ-033 r_ready held low 5 cycles -> r payload stable; rst_i pulsed in WRITE after 2 of 4 beats -> no B, busy_o 0, first 2 words written.
